// File: rtl/weight_pattern_gen.sv
// Enumerates every WIDTH-bit word with exactly k ones, in increasing order,
// one word per valid/ready beat (Gosper's next-combination step).
module weight_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int KW    = 5,
  parameter int CW    = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KW-1:0]     weight,
  input  logic              abort,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  pattern,
  output logic              last,
  output logic [CW-1:0]     count,
  output logic              done,
  output logic              err
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [KW-1:0] WIDTH_K = KW'(WIDTH);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] top_mask;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] first_top;
  logic             first_last;
  logic             bad_weight;
  logic [WIDTH:0]   succ;
  logic             load, accept, finish, reject, stop;

  // Trailing-zero position of a one-hot (or zero) vector; lowest set bit wins.
  function automatic logic [IW-1:0] ctz(input logic [WIDTH:0] v);
    ctz = '0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (v[i]) ctz = IW'(i);
    end
  endfunction

  // Next larger word with the same popcount, carried one bit wider so the
  // ripple out of the top bit never aliases back into range.
  function automatic logic [WIDTH:0] gosper(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] xe, c, r;
    xe = {1'b0, x};
    c  = xe & (-xe);
    r  = xe + c;
    gosper = r | (((r ^ xe) >> 2) >> ctz(c));
  endfunction

  assign first_word = ~({WIDTH{1'b1}} << weight);
  assign first_top  = {WIDTH{1'b1}} << (WIDTH_K - weight);
  assign first_last = (weight == '0) || (weight == WIDTH_K);
  assign bad_weight = weight > WIDTH_K;
  assign succ       = gosper(pattern);

  assign busy      = (state == RUN);
  assign out_valid = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    reject     = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE: begin
        // abort outranks start so a simultaneous request is dropped
        if (start && !abort) begin
          if (bad_weight) begin
            reject = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          stop       = 1'b1;
          state_next = IDLE;
        end else if (out_ready) begin
          accept = 1'b1;
          if (last) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern  <= '0;
      top_mask <= '0;
      last     <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= finish;
      err  <= reject;
      if (load) begin
        pattern  <= first_word;
        top_mask <= first_top;
        last     <= first_last;
        count    <= '0;
      end else if (stop) begin
        last <= 1'b0;
      end else if (accept) begin
        count <= count + CW'(1);
        if (last) begin
          last <= 1'b0;
        end else begin
          pattern <= succ[WIDTH-1:0];
          last    <= (succ == {1'b0, top_mask});
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Directed bench for weight_pattern_gen: enumeration order, handshake,
// boundary weights, error pulse, abort and asynchronous reset.
module tb_weight_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  weight;
  logic        abort;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pattern;
  logic        last;
  logic [13:0] count;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  weight_pattern_gen #(.WIDTH(16), .KW(5), .CW(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .weight    (weight),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pattern   (pattern),
    .last      (last),
    .count     (count),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  {31'b0, busy},      32'd0);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_last"},  {31'b0, last},      32'd0);
    chk({tag, "_done"},  {31'b0, done},      32'd0);
    chk({tag, "_err"},   {31'b0, err},       32'd0);
    chk({tag, "_pat"},   {16'b0, pattern},   32'd0);
    chk({tag, "_cnt"},   {18'b0, count},     32'd0);
  endtask

  // Runs one full enumeration for weight k; exp4 holds the first four
  // expected words, word 0 in the low 16 bits.
  task automatic run_enum(input int k, input bit rand_ready, input int exp_n,
                          input logic [63:0] exp4, input logic [15:0] exp_final);
    int          acc;
    int          cyc;
    logic [15:0] prev;
    logic [15:0] held;
    logic [13:0] held_cnt;
    bit          have_prev;
    bit          stalled;
    acc = 0; cyc = 0; prev = '0; held = '0; held_cnt = '0;
    have_prev = 0; stalled = 0;
    out_ready = 1'b0;
    start = 1'b1; weight = 5'(k);
    tick();
    start = 1'b0;
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_busy",  {31'b0, busy},      32'd1);
    chk("first_cnt",   {18'b0, count},     32'd0);
    while (!done && cyc < 40000) begin
      if (stalled) begin
        chk("stall_pat", {16'b0, pattern}, {16'b0, held});
        chk("stall_cnt", {18'b0, count},   {18'b0, held_cnt});
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (acc < 4) chk("seq_word", {16'b0, pattern}, {16'b0, exp4[acc*16 +: 16]});
        chk("popcount", $countones(pattern), k);
        chk("last_flag", {31'b0, last}, {31'b0, (pattern == exp_final)});
        chk("run_cnt", {18'b0, count}, acc);
        if (have_prev) chk("increasing", {31'b0, (pattern > prev)}, 32'd1);
        prev = pattern; have_prev = 1; acc++;
        stalled = 0;
      end else begin
        stalled  = out_valid;
        held     = pattern;
        held_cnt = count;
      end
      tick();
      cyc++;
    end
    chk("done_seen",   {31'b0, done},      32'd1);
    chk("done_valid",  {31'b0, out_valid}, 32'd0);
    chk("done_busy",   {31'b0, busy},      32'd0);
    chk("final_word",  {16'b0, prev},      {16'b0, exp_final});
    chk("done_cnt",    {18'b0, count},     exp_n);
    chk("accepted",    acc,                exp_n);
    if (!rand_ready) chk("throughput", cyc, exp_n);
    out_ready = 1'b1;
    tick();
    chk("done_pulse_end", {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; weight = '0; abort = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    run_enum(1,  1'b0, 16,    64'h0008_0004_0002_0001, 16'h8000);
    run_enum(2,  1'b0, 120,   64'h0009_0006_0005_0003, 16'hC000);
    run_enum(0,  1'b0, 1,     64'h0000_0000_0000_0000, 16'h0000);
    run_enum(16, 1'b0, 1,     64'h0000_0000_0000_FFFF, 16'hFFFF);

    // Over-range weight: error pulse, no run.
    start = 1'b1; weight = 5'd17;
    tick();
    start = 1'b0;
    chk("err_pulse", {31'b0, err},       32'd1);
    chk("err_valid", {31'b0, out_valid}, 32'd0);
    chk("err_busy",  {31'b0, busy},      32'd0);
    tick();
    chk("err_clear", {31'b0, err},       32'd0);
    chk("err_valid2", {31'b0, out_valid}, 32'd0);

    run_enum(8,  1'b1, 12870, 64'h01DF_01BF_017F_00FF, 16'hFF00);

    // Abort after ten accepted words of k=4; a start during the run is ignored.
    start = 1'b1; weight = 5'd4; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("k4_first", {16'b0, pattern}, 32'h000F);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3); weight = 5'd20;
      tick();
      if (i == 3) chk("start_in_run_err", {31'b0, err}, 32'd0);
    end
    start = 1'b0;
    chk("k4_cnt10",  {18'b0, count},     32'd10);
    chk("k4_busy",   {31'b0, busy},      32'd1);
    out_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy",  {31'b0, busy},      32'd0);
    chk("abort_done",  {31'b0, done},      32'd0);
    chk("abort_cnt",   {18'b0, count},     32'd10);
    chk("abort_pat",   {16'b0, pattern},   32'h0035);
    tick();
    chk("abort_done2", {31'b0, done},      32'd0);

    // abort and start together in IDLE: start dropped.
    abort = 1'b1; start = 1'b1; weight = 5'd3;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_wins_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_wins_busy",  {31'b0, busy},      32'd0);

    // Fresh k=3 run, then asynchronous reset in the middle of it.
    out_ready = 1'b1; start = 1'b1; weight = 5'd3;
    tick();
    start = 1'b0;
    chk("k3_first", {16'b0, pattern}, 32'h0007);
    chk("k3_cnt0",  {18'b0, count},   32'd0);
    tick();
    tick();
    chk("k3_third", {16'b0, pattern}, 32'h000D);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_pattern_gen.md
Name: weight_pattern_gen

Overview:
- Inverse companion of the 16-bit ones-counter. Given a target Hamming weight k, emits every WIDTH-bit word with exactly k ones.
- Words come out in strictly increasing numeric order, one per accepted valid/ready beat.
- Used as a stimulus source for the adder/popcount datapaths on the EBAZ4205 board and as a self-check generator.

Parameters:
- WIDTH, 16, pattern width in bits.
- KW, 5, width of weight input; must satisfy 2^KW > WIDTH.
- CW, 14, width of emitted-count output; sized for C(16,8)=12870.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new enumeration; sampled only in IDLE.
- weight  input  KW  target number of ones k; sampled with start.
- abort  input  1  synchronous cancel of a running enumeration.
- busy  output  1  high while in RUN.
- out_valid  output  1  pattern holds a valid word.
- out_ready  input  1  downstream accepts pattern this cycle.
- pattern  output  WIDTH  current word.
- last  output  1  current word is the final one for this k.
- count  output  CW  number of words accepted so far in this run.
- done  output  1  one-cycle pulse after the last word is accepted.
- err  output  1  one-cycle pulse when start arrives with weight > WIDTH.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, out_valid, last, done, err = 0; pattern = 0; count = 0.
- States: IDLE, RUN.
- IDLE, start=1, weight<=WIDTH:
  - Next state RUN.
  - pattern <= (1<<k)-1; out_valid=1 and busy=1 from the next cycle (latency 1).
  - count <= 0; last <= (k==0 || k==WIDTH).
- IDLE, start=1, weight>WIDTH: err=1 for one cycle; stay IDLE; no output.
- RUN, handshake (out_valid && out_ready):
  - count increments.
  - If last=1: go to IDLE, out_valid=0, done=1 for one cycle.
  - Otherwise pattern <= successor, same cycle boundary. Throughput is 1 word/cycle with out_ready held high.
- Successor rule (Gosper) for x:
  - c = x & -x; r = x + c.
  - next = r | (((r ^ x) >> 2) >> ctz(c)), where ctz is the trailing-zero position from a priority encoder. No divider is used.
  - All arithmetic is WIDTH+1 bits wide.
  - last <= 1 when next equals the top-k-bits mask (ones in bits WIDTH-1..WIDTH-k).
- Backpressure: while out_valid && !out_ready, pattern, last and count are held stable.
- Boundary values of k:
  - k=0: exactly one word, 0x0000, with last=1.
  - k=WIDTH: exactly one word, 0xFFFF, with last=1.
- start during RUN is ignored and does not raise err.
- abort in RUN: next cycle state=IDLE, out_valid=0, busy=0, no done pulse; pattern and count keep their last value.
- abort in IDLE: no effect. abort together with start in IDLE: abort wins, start is dropped.
- Reset mid-run: immediate return to reset values; no done pulse.
- count in the done cycle equals C(WIDTH,k).
- Invariants: every emitted word has popcount k; words are strictly increasing.

Test Plan:
- k=1, out_ready=1: 16 words 0x0001,0x0002,…,0x8000 on consecutive cycles; last only on 0x8000; done one cycle later; count=16.
- k=2: first words 0x0003,0x0005,0x0006,0x0009; last word 0xC000; count=120 at done.
- k=0 → single word 0x0000 with last=1; k=16 → single word 0xFFFF with last=1; done follows each; k=17 → err pulse, out_valid stays 0.
- k=8 with random out_ready:
  - 12870 words, each with popcount 8 checked against the ones counter.
  - Words strictly increasing, last word 0xFF00.
  - pattern stable on every stalled cycle.
- Abort and reset:
  - k=4, abort after 10 accepted words → out_valid=0 next cycle, no done.
  - Then start k=3 → first word 0x0007.
  - Assert rst_n=0 mid-run → all outputs 0 asynchronously.
